// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: state encoding and frame sizing helpers
// shared by the spi_reg_initiator slice.
package spi_reg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_RD_REQ,
      S_DATA,
      S_WR_REQ,
      S_DONE
   } state_e;

   function automatic int frame_len(
      input int addr_w,
      input int reg_w
   );
      return 1 + addr_w + reg_w;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-FF synchronizer for an asynchronous pad signal,
// with single-cycle rise/fall pulses on the synchronized value.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [2:0] sh_q;
   logic [2:0] sh_d;

   always_comb begin
      sh_d = {sh_q[1:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q <= {3{RST_VAL}};
      end else begin
         sh_q <= sh_d;
      end
   end

   assign rise = sh_q[1] & ~sh_q[2];
   assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_reg_initiator.sv
// spi_reg_initiator: SPI mode-0 frames to register-bank requests.
// Optional bus-ack timeout: define SPI_REG_TIMEOUT_EN.
module spi_reg_initiator
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int REG_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              wr_rdn,
   output logic [ADDR_W-1:0] addr,
   output logic [REG_W-1:0]  wdata,
   output logic              we,
   input  logic [REG_W-1:0]  rdata,
   input  logic              ack,
   input  logic              err,
   output logic              err_flag
);

   localparam int FRAME_LEN = frame_len(ADDR_W, REG_W);
   localparam int CW = cnt_w(FRAME_LEN);
   localparam logic [CW-1:0] LAST_CMD = CW'(ADDR_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

   logic sclk_rise, sclk_fall;
   logic cs_rise, cs_fall;
   logic [1:0] mosi_q, mosi_d;
   logic mosi_s;

   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] cmd_q, cmd_d;
   logic [REG_W-2:0] wsr_q, wsr_d;
   logic [REG_W-1:0] tx_q, tx_d;
   logic miso_q, miso_d;
   logic we_q, we_d;
   logic wr_rdn_q, wr_rdn_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [REG_W-1:0] wdata_q, wdata_d;
   logic err_q, err_d;
   logic rd_have;
   logic [REG_W-1:0] rd_val;
   logic to_expire;

   spi_sync #(.RST_VAL(1'b0)) u_sclk (
      .clk  (clk),
      .rst  (rst),
      .d    (spi_sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync #(.RST_VAL(1'b1)) u_cs (
      .clk  (clk),
      .rst  (rst),
      .d    (spi_cs_n),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   always_comb begin
      mosi_d = {mosi_q[0], spi_mosi};
   end
   assign mosi_s = mosi_q[1];

`ifdef SPI_REG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_q, to_d;

   always_comb begin
      to_expire = we_q && !ack
                  && (to_q == TW'(TIMEOUT - 1));
      to_d = (we_q && !ack && !to_expire)
             ? to_q + 1'b1 : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`else
   assign to_expire = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      wsr_d    = wsr_q;
      tx_d     = tx_q;
      miso_d   = miso_q;
      we_d     = we_q;
      wr_rdn_d = wr_rdn_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rd_have  = we_q && ack;
      rd_val   = rdata;
      // the request lives independently of the frame state
      if (we_q && ack) begin
         we_d = 1'b0;
         if (err) begin
            err_d = 1'b1;
         end
      end
      if (to_expire) begin
         we_d    = 1'b0;
         err_d   = 1'b1;
         rd_have = 1'b1;
         rd_val  = '1;
      end
      if (!ena || (cs_rise && state_q != S_IDLE)) begin
         state_d = S_IDLE;
         miso_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cs_fall && !we_q) begin
                  state_d = S_CMD;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  tx_d    = '0;
                  miso_d  = 1'b0;
               end
            end
            S_CMD: begin
               if (sclk_rise) begin
                  cnt_d = cnt_q + 1'b1;
                  cmd_d = {cmd_q[ADDR_W-2:0], mosi_s};
                  if (cnt_q == LAST_CMD) begin
                     wr_rdn_d = cmd_q[ADDR_W-1];
                     addr_d   = {cmd_q[ADDR_W-2:0], mosi_s};
                     if (cmd_q[ADDR_W-1]) begin
                        state_d = S_DATA;
                     end else begin
                        we_d    = 1'b1;
                        state_d = S_RD_REQ;
                     end
                  end
               end
            end
            S_RD_REQ: begin
               if (rd_have || sclk_fall) begin
                  state_d = S_DATA;
               end
               if (sclk_fall && rd_have) begin
                  miso_d = rd_val[REG_W-1];
                  tx_d   = rd_val << 1;
               end else if (sclk_fall) begin
                  miso_d = 1'b0;
                  tx_d   = '0;
                  err_d  = 1'b1;
               end else if (rd_have) begin
                  tx_d = rd_val;
               end
            end
            S_DATA: begin
               if (sclk_fall) begin
                  miso_d = tx_q[REG_W-1];
                  tx_d   = tx_q << 1;
               end
               if (sclk_rise) begin
                  cnt_d = cnt_q + 1'b1;
                  wsr_d = {wsr_q[REG_W-3:0], mosi_s};
                  if (cnt_q == LAST_BIT) begin
                     miso_d = 1'b0;
                     if (wr_rdn_q) begin
                        wdata_d = {wsr_q, mosi_s};
                        we_d    = 1'b1;
                        state_d = S_WR_REQ;
                     end else begin
                        state_d = S_DONE;
                     end
                  end
               end
            end
            S_WR_REQ: begin
               if (!we_d) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_q   <= '0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         cmd_q    <= '0;
         wsr_q    <= '0;
         tx_q     <= '0;
         miso_q   <= 1'b0;
         we_q     <= 1'b0;
         wr_rdn_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         mosi_q   <= mosi_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         wsr_q    <= wsr_d;
         tx_q     <= tx_d;
         miso_q   <= miso_d;
         we_q     <= we_d;
         wr_rdn_q <= wr_rdn_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
      end
   end

   assign spi_miso = miso_q;
   assign we       = we_q;
   assign wr_rdn   = wr_rdn_q;
   assign addr     = addr_q;
   assign wdata    = wdata_q;
   assign err_flag = err_q;

endmodule
